// File: rtl/adder_arbiter.sv
// -----------------------------------------------------------------------------
// adder_arbiter
//
// Shares one WIDTH-bit two's-complement add/subtract unit between four
// requesters using round-robin arbitration. An accepted request is captured
// on its grant edge, executed on the following edge and returned with the
// requester index and carry/overflow flags. One operation every two cycles.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-high reset
//   req          per-requester request level, held until granted
//   req_sub      per-requester op select: 1 = a - b, 0 = a + b
//   req_a        operand a, requester i at [i*WIDTH +: WIDTH]
//   req_b        operand b, same packing
//   grant        one-hot, one-cycle pulse on the capture edge
//   busy         high while the accepted operation is in EXEC
//   result       sum/difference, held until the next result_valid
//   result_valid one-cycle pulse when result is updated
//   result_id    index of the requester owning result
//   carry        carry-out (add) / NOT borrow (sub)
//   overflow     signed overflow of the operation
// -----------------------------------------------------------------------------
module adder_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [3:0]           req,
  input  logic [3:0]           req_sub,
  input  logic [4*WIDTH-1:0]   req_a,
  input  logic [4*WIDTH-1:0]   req_b,
  output logic [3:0]           grant,
  output logic                 busy,
  output logic [WIDTH-1:0]     result,
  output logic                 result_valid,
  output logic [1:0]           result_id,
  output logic                 carry,
  output logic                 overflow
);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t             state_q, state_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic               op_sub_q, op_sub_d;
  logic [1:0]         op_id_q, op_id_d;

  logic [3:0]         grant_d;
  logic               busy_d;
  logic [WIDTH-1:0]   result_d;
  logic               result_valid_d;
  logic [1:0]         result_id_d;
  logic               carry_d;
  logic               overflow_d;

  // Arbitration and datapath helpers
  logic               found;
  logic [1:0]         win;
  logic [1:0]         scan_idx;
  int                 win_base;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH:0]     sum;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can infer a latch.
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    op_sub_d       = op_sub_q;
    op_id_d        = op_id_q;
    grant_d        = '0;
    busy_d         = 1'b0;
    result_d       = result;
    result_valid_d = 1'b0;
    result_id_d    = result_id;
    carry_d        = carry;
    overflow_d     = overflow;

    // First set request scanning from rr_ptr upward, wrapping mod 4.
    found    = 1'b0;
    win      = rr_ptr_q;
    scan_idx = rr_ptr_q;
    for (int k = 0; k < 4; k++) begin
      scan_idx = rr_ptr_q + 2'(k);
      if (!found && req[scan_idx]) begin
        found = 1'b1;
        win   = scan_idx;
      end
    end
    win_base = int'(win) * WIDTH;

    // Subtraction is a + ~b + 1; the +1 enters as the carry-in.
    b_eff = op_sub_q ? ~op_b_q : op_b_q;
    sum   = {1'b0, op_a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op_sub_q};

    case (state_q)
      IDLE: begin
        if (found) begin
          op_a_d       = req_a[win_base +: WIDTH];
          op_b_d       = req_b[win_base +: WIDTH];
          op_sub_d     = req_sub[win];
          op_id_d      = win;
          grant_d[win] = 1'b1;
          busy_d       = 1'b1;
          rr_ptr_d     = win + 2'd1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        result_d       = sum[WIDTH-1:0];
        carry_d        = sum[WIDTH];
        // Same-sign inputs producing an opposite-sign result overflow.
        overflow_d     = (op_a_q[WIDTH-1] == b_eff[WIDTH-1]) &&
                         (sum[WIDTH-1] != op_a_q[WIDTH-1]);
        result_valid_d = 1'b1;
        result_id_d    = op_id_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      // NOTE: the operand registers are plain flops, not a memory, so they are
      // reset along with everything else and never carry X into the adder.
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_sub_q     <= 1'b0;
      op_id_q      <= '0;
      grant        <= '0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      result_id    <= '0;
      carry        <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // present before the edge, independent of statement order.
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_sub_q     <= op_sub_d;
      op_id_q      <= op_id_d;
      grant        <= grant_d;
      busy         <= busy_d;
      result       <= result_d;
      result_valid <= result_valid_d;
      result_id    <= result_id_d;
      carry        <= carry_d;
      overflow     <= overflow_d;
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_arbiter
//
// Directed self-checking bench for adder_arbiter. Inputs are driven 1 time
// unit after each rising edge and outputs are sampled at the same point, so
// nothing is read on the active edge. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_adder_arbiter;

  localparam int WIDTH = 32;

  logic                 clock;
  logic                 reset;
  logic [3:0]           req;
  logic [3:0]           req_sub;
  logic [4*WIDTH-1:0]   req_a;
  logic [4*WIDTH-1:0]   req_b;
  logic [3:0]           grant;
  logic                 busy;
  logic [WIDTH-1:0]     result;
  logic                 result_valid;
  logic [1:0]           result_id;
  logic                 carry;
  logic                 overflow;

  int vectors     = 0;
  int miscompares = 0;

  adder_arbiter #(.WIDTH(WIDTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .req_sub      (req_sub),
    .req_a        (req_a),
    .req_b        (req_b),
    .grant        (grant),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .result_id    (result_id),
    .carry        (carry),
    .overflow     (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic load(input int idx, input logic [31:0] a, input logic [31:0] b,
                      input logic sub);
    req_a[idx*WIDTH +: WIDTH] = a;
    req_b[idx*WIDTH +: WIDTH] = b;
    req_sub[idx]              = sub;
  endtask

  // Single requester, full grant -> result -> hold sequence.
  task automatic do_op(input string tag, input int idx, input logic [31:0] a,
                       input logic [31:0] b, input logic sub,
                       input logic [31:0] er, input logic ec, input logic eo);
    logic [3:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    load(idx, a, b, sub);
    req = oh;
    tick;
    check({tag, ".grant"}, 32'(grant), 32'(oh));
    check({tag, ".busy"}, 32'(busy), 32'd1);
    req = '0;
    tick;
    check({tag, ".valid"}, 32'(result_valid), 32'd1);
    check({tag, ".result"}, result, er);
    check({tag, ".id"}, 32'(result_id), 32'(idx));
    check({tag, ".carry"}, 32'(carry), 32'(ec));
    check({tag, ".ovf"}, 32'(overflow), 32'(eo));
    check({tag, ".busy_clr"}, 32'(busy), 32'd0);
    tick;
    check({tag, ".valid_pulse"}, 32'(result_valid), 32'd0);
    check({tag, ".hold"}, result, er);
  endtask

  logic [31:0] rr_exp [4];
  logic [3:0]  oh_rr;

  initial begin
    reset   = 1'b1;
    req     = '0;
    req_sub = '0;
    req_a   = '0;
    req_b   = '0;
    rr_exp[0] = 32'h0000_0010;
    rr_exp[1] = 32'h0000_0021;
    rr_exp[2] = 32'h0000_0032;
    rr_exp[3] = 32'h0000_003D;

    // Reset state
    tick;
    tick;
    check("rst.grant", 32'(grant), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.result", result, 32'd0);
    check("rst.valid", 32'(result_valid), 32'd0);
    check("rst.id", 32'(result_id), 32'd0);
    check("rst.carry", 32'(carry), 32'd0);
    check("rst.ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    tick;

    // Reset mid-EXEC aborts the operation and clears rr_ptr
    load(0, 32'd9, 32'd9, 1'b0);
    req = 4'b0001;
    tick;
    check("midrst.grant", 32'(grant), 32'b0001);
    check("midrst.busy", 32'(busy), 32'd1);
    req = '0;
    #1;
    reset = 1'b1;
    #1;
    check("midrst.async_grant", 32'(grant), 32'd0);
    check("midrst.async_busy", 32'(busy), 32'd0);
    check("midrst.async_valid", 32'(result_valid), 32'd0);
    tick;
    reset = 1'b0;
    tick;
    check("midrst.no_result1", 32'(result_valid), 32'd0);
    tick;
    check("midrst.no_result2", 32'(result_valid), 32'd0);

    // rr_ptr back at 0: requester 0 beats requester 1
    load(1, 32'd1, 32'd1, 1'b0);
    req = 4'b0011;
    tick;
    check("postrst.grant", 32'(grant), 32'b0001);
    req = '0;
    tick;
    check("postrst.valid", 32'(result_valid), 32'd1);
    check("postrst.result", result, 32'd18);
    check("postrst.id", 32'(result_id), 32'd0);
    tick;

    // Arithmetic cases
    do_op("add5p7",  2, 32'd5,         32'd7,         1'b0, 32'd12,        1'b0, 1'b0);
    do_op("sub3m5",  1, 32'd3,         32'd5,         1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    do_op("subminm1",3, 32'h8000_0000, 32'd1,         1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    do_op("addmaxp1",0, 32'h7FFF_FFFF, 32'd1,         1'b0, 32'h8000_0000, 1'b0, 1'b1);
    do_op("addwrap", 0, 32'hFFFF_FFFF, 32'd1,         1'b0, 32'd0,         1'b1, 1'b0);
    do_op("sub0mmin",2, 32'd0,         32'h8000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
    do_op("sub10m4", 3, 32'd10,        32'd4,         1'b1, 32'd6,         1'b1, 1'b0);

    // Round robin from rr_ptr = 0, each requester dropping on its grant
    load(0, 32'h10, 32'd0, 1'b0);
    load(1, 32'h20, 32'd1, 1'b0);
    load(2, 32'h30, 32'd2, 1'b0);
    load(3, 32'h40, 32'd3, 1'b1);
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      oh_rr    = '0;
      oh_rr[i] = 1'b1;
      tick;
      check($sformatf("rr.grant%0d", i), 32'(grant), 32'(oh_rr));
      req[i] = 1'b0;
      tick;
      check($sformatf("rr.valid%0d", i), 32'(result_valid), 32'd1);
      check($sformatf("rr.id%0d", i), 32'(result_id), 32'(i));
      check($sformatf("rr.result%0d", i), result, rr_exp[i]);
    end
    tick;
    check("rr.idle_grant", 32'(grant), 32'd0);

    // Requester 0 holds req; requester 3 arrives during EXEC
    load(0, 32'd100, 32'd1, 1'b0);
    req = 4'b0001;
    tick;
    check("fair.grant0", 32'(grant), 32'b0001);
    load(3, 32'd50, 32'd8, 1'b1);
    req[3] = 1'b1;
    tick;
    check("fair.valid0", 32'(result_valid), 32'd1);
    check("fair.result0", result, 32'd101);
    check("fair.no_grant_exec", 32'(grant), 32'd0);
    tick;
    check("fair.grant3", 32'(grant), 32'b1000);
    req[3] = 1'b0;
    tick;
    check("fair.id3", 32'(result_id), 32'd3);
    check("fair.result3", result, 32'd42);
    tick;
    check("fair.grant0_again", 32'(grant), 32'b0001);
    req = '0;
    tick;
    check("fair.id0", 32'(result_id), 32'd0);
    check("fair.result0b", result, 32'd101);
    tick;
    check("fair.no_double", 32'(grant), 32'd0);
    check("fair.idle_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
